mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit directly downstream of the EX/MEM pipeline register.
- Drives that register's `Mready` (`in_ready`) and consumes its M-side fields.
- Aligns store data and byte strobes, issues one request on a valid/ready data-memory port, and waits for the response.
- Sign- or zero-extends load data, then presents the completed instruction to the MEM/WB register through a valid/ready handshake.

Parameters:
- DATA_W, 32, data/address width.
- REG_W, 5, register index width.
- ROPCODE_W, 3, load opcode width.
- RSRC_W, 2, result-source select width.
- WMASK_W, 4, byte-strobe width (DATA_W/8).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  EX/MEM entry holds a valid instruction.
- in_ready  out  1  block can accept (drives EX/MEM `Mready`).
- in_regwrite, in_memread, in_memwrite, in_csrwrite  in  1 each  control bits.
- in_wmask  in  WMASK_W  unshifted store mask (0x1 byte, 0x3 half, 0xF word).
- in_ropcode  in  ROPCODE_W  load kind: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- in_result_src  in  RSRC_W  passthrough.
- in_wdata, in_pcplus4, in_csrread, in_alu_result  in  DATA_W  store data / passthroughs; in_alu_result is the address.
- in_rd  in  REG_W  destination register.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  DATA_W  word-aligned address (addr[1:0] = 0).
- mem_req_wdata  out  DATA_W  lane-shifted store data.
- mem_req_wstrb  out  WMASK_W  lane-shifted strobes.
- mem_resp_valid  in  1  read data or write ack.
- mem_resp_rdata  in  DATA_W  read word.
- out_valid  out  1  completed instruction available.
- out_ready  in  1  MEM/WB accepts.
- out_regwrite, out_csrwrite  out  1  passthrough; forced 0 when out_misaligned.
- out_result_src  out  RSRC_W  passthrough.
- out_alu_result, out_pcplus4, out_csrread  out  DATA_W  passthrough.
- out_load_data  out  DATA_W  extended load result.
- out_rd  out  REG_W  passthrough.
- out_misaligned  out  1  access was misaligned; no memory access performed.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- in_ready = (state == IDLE). The block captures all in_* fields into internal registers when in_valid && in_ready.
- Capture in IDLE selects the next state:
  - misaligned (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0) -> DONE with out_misaligned = 1.
  - in_memread or in_memwrite -> REQ.
  - otherwise -> DONE.
  - Non-memory latency: out_valid asserts 1 cycle after capture.
- REQ:
  - mem_req_valid = 1; address, data and strobes stay stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready -> WAIT.
- WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid, register the extended read data (loads only) -> DONE.
  - Writes also wait for mem_resp_valid (ack).
- mem_resp_valid outside WAIT is ignored. The memory never returns a response in the same cycle it accepts a request.
- DONE: out_valid = 1; all out_* hold stable. On out_ready -> IDLE.
  - No bypass: a new instruction is accepted at the earliest in the IDLE cycle after the handoff.
- Alignment with sh = addr[1:0]:
  - mem_req_addr = {addr[DATA_W-1:2], 2'b00}.
  - mem_req_wstrb = in_wmask << sh (truncated to WMASK_W).
  - mem_req_wdata = in_wdata << (8*sh).
- Load extract with w = rdata >> (8*sh):
  - LB: sext(w[7:0]); LBU: zext(w[7:0]).
  - LH: sext(w[15:0]); LHU: zext(w[15:0]).
  - LW: w.
  - Any other ropcode: zext(w[7:0]).
- out_load_data = 0 for non-load and misaligned instructions.
- Reset (synchronous, resetn = 0), including mid-REQ/WAIT:
  - state -> IDLE; mem_req_valid = 0; out_valid = 0.
  - All captured registers and out_* -> 0; out_misaligned -> 0.
  - A response from an abandoned request arriving after reset is ignored (state is IDLE).
- Outputs reset values: in_ready = 1 after reset; mem_req_we/addr/wdata/wstrb = 0 in IDLE, DONE and reset.

Test Plan:
- ALU op: in_valid, regwrite = 1, rd = 5, alu = 0x1234 -> out_valid next cycle; out_rd = 5, out_alu_result = 0x1234, no mem_req_valid; held until out_ready, then in_ready = 1.
- LB at 0x80000003, rdata = 0x80FF_0000 with mem_req_ready 2 cycles late -> addr 0x80000000 held stable across stall; out_load_data = 0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH at 0x80000002, wdata = 0x0000BEEF, wmask = 0x3 -> wstrb = 0xC, wdata = 0xBEEF0000, we = 1; out_valid only after ack.
- LW at 0x80000001 -> no request, out_misaligned = 1, out_regwrite = 0, out_load_data = 0.
- Backpressure: out_ready = 0 for 4 cycles after a load completes -> out_* stable, in_ready = 0, a new EX/MEM entry is not accepted.
- resetn low in WAIT, then a stale mem_resp_valid -> state IDLE, out_valid stays 0, in_ready = 1, stale data never appears.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//
// MEM-stage load/store unit sitting directly after the EX/MEM pipeline
// register. It accepts one instruction at a time, aligns store data and byte
// strobes onto the 32-bit word lanes, issues a single request on the
// valid/ready data-memory port and waits for the response. Loads are then
// sign- or zero-extended. The finished instruction is offered to the MEM/WB
// register on a valid/ready handshake.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   in_valid/in_ready  EX/MEM handshake (in_ready drives EX/MEM Mready)
//   in_*               control bits, store mask, load opcode, store data,
//                      passthrough fields; in_alu_result is the address
//   mem_req_*          data-memory request (word-aligned address, lane-shifted
//                      data and strobes), held stable until mem_req_ready
//   mem_resp_*         read data or write acknowledge
//   out_valid/out_ready MEM/WB handshake
//   out_*              passthrough fields, extended load data, misaligned flag
module mem_stage_lsu #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int ROPCODE_W = 3,
  parameter int RSRC_W    = 2,
  parameter int WMASK_W   = 4
) (
  input  logic                 clk,
  input  logic                 resetn,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_regwrite,
  input  logic                 in_memread,
  input  logic                 in_memwrite,
  input  logic                 in_csrwrite,
  input  logic [WMASK_W-1:0]   in_wmask,
  input  logic [ROPCODE_W-1:0] in_ropcode,
  input  logic [RSRC_W-1:0]    in_result_src,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic [DATA_W-1:0]    in_pcplus4,
  input  logic [DATA_W-1:0]    in_csrread,
  input  logic [DATA_W-1:0]    in_alu_result,
  input  logic [REG_W-1:0]     in_rd,

  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [DATA_W-1:0]    mem_req_addr,
  output logic [DATA_W-1:0]    mem_req_wdata,
  output logic [WMASK_W-1:0]   mem_req_wstrb,
  input  logic                 mem_resp_valid,
  input  logic [DATA_W-1:0]    mem_resp_rdata,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_regwrite,
  output logic                 out_csrwrite,
  output logic [RSRC_W-1:0]    out_result_src,
  output logic [DATA_W-1:0]    out_alu_result,
  output logic [DATA_W-1:0]    out_pcplus4,
  output logic [DATA_W-1:0]    out_csrread,
  output logic [DATA_W-1:0]    out_load_data,
  output logic [REG_W-1:0]     out_rd,
  output logic                 out_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ROPCODE_W-1:0] OP_LB  = ROPCODE_W'(0);
  localparam logic [ROPCODE_W-1:0] OP_LH  = ROPCODE_W'(1);
  localparam logic [ROPCODE_W-1:0] OP_LW  = ROPCODE_W'(2);
  localparam logic [ROPCODE_W-1:0] OP_LBU = ROPCODE_W'(4);
  localparam logic [ROPCODE_W-1:0] OP_LHU = ROPCODE_W'(5);

  localparam logic [WMASK_W-1:0] MASK_HALF = WMASK_W'(4'h3);
  localparam logic [WMASK_W-1:0] MASK_WORD = WMASK_W'(4'hF);

  state_t state_q, state_d;

  logic                 regwrite_q,   regwrite_d;
  logic                 csrwrite_q,   csrwrite_d;
  logic                 memread_q,    memread_d;
  logic                 misaligned_q, misaligned_d;
  logic [ROPCODE_W-1:0] ropcode_q,    ropcode_d;
  logic [RSRC_W-1:0]    result_src_q, result_src_d;
  logic [DATA_W-1:0]    alu_q,        alu_d;
  logic [DATA_W-1:0]    pcplus4_q,    pcplus4_d;
  logic [DATA_W-1:0]    csrread_q,    csrread_d;
  logic [REG_W-1:0]     rd_q,         rd_d;
  logic [DATA_W-1:0]    load_data_q,  load_data_d;

  logic                 req_valid_q,  req_valid_d;
  logic                 req_we_q,     req_we_d;
  logic [DATA_W-1:0]    req_addr_q,   req_addr_d;
  logic [DATA_W-1:0]    req_wdata_q,  req_wdata_d;
  logic [WMASK_W-1:0]   req_wstrb_q,  req_wstrb_d;

  logic                 out_valid_q,  out_valid_d;

  // Alignment checks on the incoming instruction. Load width comes from the
  // opcode, store width from the unshifted byte mask.
  logic [1:0] sh_in;
  logic       half_ld, word_ld, half_st, word_st;
  logic       misaligned_in;

  always_comb begin
    sh_in   = in_alu_result[1:0];
    half_ld = (in_ropcode == OP_LH) || (in_ropcode == OP_LHU);
    word_ld = (in_ropcode == OP_LW);
    half_st = (in_wmask == MASK_HALF);
    word_st = (in_wmask == MASK_WORD);
    misaligned_in =
      (in_memread  && ((half_ld && sh_in[0]) || (word_ld && (sh_in != 2'b00)))) ||
      (in_memwrite && ((half_st && sh_in[0]) || (word_st && (sh_in != 2'b00))));
  end

  // Load extraction: shift the addressed byte/half down to lane 0, then
  // extend according to the captured opcode. Unknown opcodes behave as LBU.
  logic [DATA_W-1:0] rshift;
  logic [DATA_W-1:0] load_ext;

  always_comb begin
    rshift = mem_resp_rdata >> {alu_q[1:0], 3'b000};
    unique case (ropcode_q)
      OP_LB:   load_ext = {{(DATA_W-8){rshift[7]}}, rshift[7:0]};
      OP_LH:   load_ext = {{(DATA_W-16){rshift[15]}}, rshift[15:0]};
      OP_LW:   load_ext = rshift;
      OP_LBU:  load_ext = {{(DATA_W-8){1'b0}}, rshift[7:0]};
      OP_LHU:  load_ext = {{(DATA_W-16){1'b0}}, rshift[15:0]};
      default: load_ext = {{(DATA_W-8){1'b0}}, rshift[7:0]};
    endcase
  end

  // Next-state logic. Request fields are loaded at capture time and cleared
  // once the memory takes them, so they read as zero outside REQ.
  always_comb begin
    state_d      = state_q;
    regwrite_d   = regwrite_q;
    csrwrite_d   = csrwrite_q;
    memread_d    = memread_q;
    misaligned_d = misaligned_q;
    ropcode_d    = ropcode_q;
    result_src_d = result_src_q;
    alu_d        = alu_q;
    pcplus4_d    = pcplus4_q;
    csrread_d    = csrread_q;
    rd_d         = rd_q;
    load_data_d  = load_data_q;
    req_valid_d  = req_valid_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    out_valid_d  = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Misaligned accesses never reach memory and must not write back.
          regwrite_d   = in_regwrite & ~misaligned_in;
          csrwrite_d   = in_csrwrite & ~misaligned_in;
          memread_d    = in_memread;
          misaligned_d = misaligned_in;
          ropcode_d    = in_ropcode;
          result_src_d = in_result_src;
          alu_d        = in_alu_result;
          pcplus4_d    = in_pcplus4;
          csrread_d    = in_csrread;
          rd_d         = in_rd;
          load_data_d  = '0;
          if (misaligned_in) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else if (in_memread || in_memwrite) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_we_d    = in_memwrite;
            req_addr_d  = {in_alu_result[DATA_W-1:2], 2'b00};
            req_wdata_d = in_memwrite ? (in_wdata << {sh_in, 3'b000}) : '0;
            req_wstrb_d = in_memwrite ? WMASK_W'(in_wmask << sh_in) : '0;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
          req_we_d    = 1'b0;
          req_addr_d  = '0;
          req_wdata_d = '0;
          req_wstrb_d = '0;
        end
      end
      WAIT: begin
        // Stores wait here too; their response is only an acknowledge.
        if (mem_resp_valid) begin
          if (memread_q) begin
            load_data_d = load_ext;
          end
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset abandons any outstanding request; a
  // late response then lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      regwrite_q   <= 1'b0;
      csrwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      misaligned_q <= 1'b0;
      ropcode_q    <= '0;
      result_src_q <= '0;
      alu_q        <= '0;
      pcplus4_q    <= '0;
      csrread_q    <= '0;
      rd_q         <= '0;
      load_data_q  <= '0;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wstrb_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      regwrite_q   <= regwrite_d;
      csrwrite_q   <= csrwrite_d;
      memread_q    <= memread_d;
      misaligned_q <= misaligned_d;
      ropcode_q    <= ropcode_d;
      result_src_q <= result_src_d;
      alu_q        <= alu_d;
      pcplus4_q    <= pcplus4_d;
      csrread_q    <= csrread_d;
      rd_q         <= rd_d;
      load_data_q  <= load_data_d;
      req_valid_q  <= req_valid_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wstrb_q  <= req_wstrb_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready       = (state_q == IDLE);

  assign mem_req_valid  = req_valid_q;
  assign mem_req_we     = req_we_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_wdata  = req_wdata_q;
  assign mem_req_wstrb  = req_wstrb_q;

  assign out_valid      = out_valid_q;
  assign out_regwrite   = regwrite_q;
  assign out_csrwrite   = csrwrite_q;
  assign out_result_src = result_src_q;
  assign out_alu_result = alu_q;
  assign out_pcplus4    = pcplus4_q;
  assign out_csrread    = csrread_q;
  assign out_load_data  = load_data_q;
  assign out_rd         = rd_q;
  assign out_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//
// Directed bench for mem_stage_lsu. Each instruction's expected MEM/WB fields
// are pushed to a queue when it is driven and compared when the DUT offers it.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic        in_regwrite, in_memread, in_memwrite, in_csrwrite;
  logic [3:0]  in_wmask;
  logic [2:0]  in_ropcode;
  logic [1:0]  in_result_src;
  logic [31:0] in_wdata, in_pcplus4, in_csrread, in_alu_result;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready;
  logic        out_regwrite, out_csrwrite;
  logic [1:0]  out_result_src;
  logic [31:0] out_alu_result, out_pcplus4, out_csrread, out_load_data;
  logic [4:0]  out_rd;
  logic        out_misaligned;

  mem_stage_lsu dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_csrwrite(in_csrwrite),
    .in_wmask(in_wmask), .in_ropcode(in_ropcode),
    .in_result_src(in_result_src), .in_wdata(in_wdata),
    .in_pcplus4(in_pcplus4), .in_csrread(in_csrread),
    .in_alu_result(in_alu_result), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_regwrite(out_regwrite), .out_csrwrite(out_csrwrite),
    .out_result_src(out_result_src), .out_alu_result(out_alu_result),
    .out_pcplus4(out_pcplus4), .out_csrread(out_csrread),
    .out_load_data(out_load_data), .out_rd(out_rd),
    .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regwrite, memread, memwrite, csrwrite;
    logic [3:0]  wmask;
    logic [2:0]  ropcode;
    logic [1:0]  result_src;
    logic [31:0] wdata, pcplus4, csrread, alu;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic        regwrite, csrwrite, misaligned;
    logic [1:0]  result_src;
    logic [31:0] alu, pcplus4, csrread, load_data;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Advance one cycle; all driving and sampling happens 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one EX/MEM entry for a single cycle and record what MEM/WB should see.
  task automatic applyStimulus(input instr_t s, input exp_t e);
    in_regwrite   = s.regwrite;
    in_memread    = s.memread;
    in_memwrite   = s.memwrite;
    in_csrwrite   = s.csrwrite;
    in_wmask      = s.wmask;
    in_ropcode    = s.ropcode;
    in_result_src = s.result_src;
    in_wdata      = s.wdata;
    in_pcplus4    = s.pcplus4;
    in_csrread    = s.csrread;
    in_alu_result = s.alu;
    in_rd         = s.rd;
    in_valid      = 1'b1;
    checkOutput("in_ready_before_capture", 32'(in_ready), 32'd1);
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Pop the scoreboard head, compare every MEM/WB field, then hand it off.
  task automatic handoff(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_rd"},         32'(out_rd),         32'(e.rd));
      checkOutput({tag, "_alu"},        out_alu_result,      e.alu);
      checkOutput({tag, "_pcplus4"},    out_pcplus4,         e.pcplus4);
      checkOutput({tag, "_csrread"},    out_csrread,         e.csrread);
      checkOutput({tag, "_load_data"},  out_load_data,       e.load_data);
      checkOutput({tag, "_regwrite"},   32'(out_regwrite),   32'(e.regwrite));
      checkOutput({tag, "_csrwrite"},   32'(out_csrwrite),   32'(e.csrwrite));
      checkOutput({tag, "_result_src"}, 32'(out_result_src), 32'(e.result_src));
      checkOutput({tag, "_misaligned"}, 32'(out_misaligned), 32'(e.misaligned));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_after_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_after_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Run the request/response exchange for an instruction now sitting in REQ.
  task automatic doMemOp(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int stall, input int ack_delay,
                         input logic [31:0] rdata);
    for (int k = 0; k <= stall; k++) begin
      checkOutput({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
      checkOutput({tag, "_req_addr"},  mem_req_addr,       addr);
      checkOutput({tag, "_req_we"},    32'(mem_req_we),    32'(we));
      checkOutput({tag, "_req_wdata"}, mem_req_wdata,      wdata);
      checkOutput({tag, "_req_wstrb"}, 32'(mem_req_wstrb), 32'(wstrb));
      if (k < stall) step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checkOutput({tag, "_wait_req_valid"}, 32'(mem_req_valid), 32'd0);
    for (int d = 0; d < ack_delay; d++) begin
      checkOutput({tag, "_wait_out_valid"}, 32'(out_valid), 32'd0);
      step();
    end
    checkOutput({tag, "_wait_out_valid"}, 32'(out_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
  endtask

  // Reference load extraction, written byte-wise from the addressed offset.
  function automatic logic [31:0] modelLoad(input logic [31:0] rdata,
                                            input logic [1:0] off,
                                            input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*off +: 8];
    h = (off == 2'd2) ? rdata[31:16] : rdata[15:0];
    case (op)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return rdata;
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return {24'h0, b};
    endcase
  endfunction

  function automatic exp_t expFrom(input instr_t s, input logic [31:0] ld,
                                   input logic mis);
    exp_t e;
    e.regwrite   = s.regwrite & ~mis;
    e.csrwrite   = s.csrwrite & ~mis;
    e.misaligned = mis;
    e.result_src = s.result_src;
    e.alu        = s.alu;
    e.pcplus4    = s.pcplus4;
    e.csrread    = s.csrread;
    e.load_data  = ld;
    e.rd         = s.rd;
    return e;
  endfunction

  initial begin
    instr_t s;
    exp_t   e;
    logic [2:0]  ops [6];
    logic [1:0]  off;
    logic [31:0] rd_word;

    resetn = 1'b0;
    in_valid = 1'b0; in_regwrite = 1'b0; in_memread = 1'b0;
    in_memwrite = 1'b0; in_csrwrite = 1'b0; in_wmask = 4'h0;
    in_ropcode = 3'd0; in_result_src = 2'd0; in_wdata = 32'h0;
    in_pcplus4 = 32'h0; in_csrread = 32'h0; in_alu_result = 32'h0; in_rd = 5'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    out_ready = 1'b0;

    $display("[TB] reset");
    step();
    step();
    checkOutput("rst_in_ready",      32'(in_ready),       32'd1);
    checkOutput("rst_out_valid",     32'(out_valid),      32'd0);
    checkOutput("rst_req_valid",     32'(mem_req_valid),  32'd0);
    checkOutput("rst_req_addr",      mem_req_addr,        32'h0);
    checkOutput("rst_req_wstrb",     32'(mem_req_wstrb),  32'h0);
    checkOutput("rst_out_misaligned",32'(out_misaligned), 32'd0);
    checkOutput("rst_out_load_data", out_load_data,       32'h0);
    resetn = 1'b1;
    step();

    $display("[TB] ALU op");
    s = '{default: '0};
    s.regwrite = 1'b1; s.csrwrite = 1'b1; s.rd = 5'd5; s.alu = 32'h1234;
    s.result_src = 2'd2; s.pcplus4 = 32'h0000_0104; s.csrread = 32'hCAFE_0001;
    applyStimulus(s, expFrom(s, 32'h0, 1'b0));
    checkOutput("alu_out_valid_next", 32'(out_valid),     32'd1);
    checkOutput("alu_no_req",         32'(mem_req_valid), 32'd0);
    checkOutput("alu_in_ready_busy",  32'(in_ready),      32'd0);
    step();
    checkOutput("alu_held_valid",     32'(out_valid),     32'd1);
    checkOutput("alu_held_rd",        32'(out_rd),        32'd5);
    handoff("alu");

    $display("[TB] LB with stalled request");
    s = '{default: '0};
    s.regwrite = 1'b1; s.memread = 1'b1; s.ropcode = 3'd0; s.rd = 5'd7;
    s.alu = 32'h8000_0003; s.result_src = 2'd1;
    applyStimulus(s, expFrom(s, 32'hFFFF_FF80, 1'b0));
    doMemOp("lb", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, 0, 32'h80FF_0000);
    waitOutValid("lb");
    handoff("lb");

    $display("[TB] LBU with stalled request");
    s.ropcode = 3'd4;
    applyStimulus(s, expFrom(s, 32'h0000_0080, 1'b0));
    doMemOp("lbu", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, 0, 32'h80FF_0000);
    waitOutValid("lbu");
    handoff("lbu");

    $display("[TB] SH upper half");
    s = '{default: '0};
    s.memwrite = 1'b1; s.wmask = 4'h3; s.wdata = 32'h0000_BEEF;
    s.alu = 32'h8000_0002; s.rd = 5'd0;
    applyStimulus(s, expFrom(s, 32'h0, 1'b0));
    doMemOp("sh", 1'b1, 32'h8000_0000, 32'hBEEF_0000, 4'hC, 0, 2, 32'h0);
    waitOutValid("sh");
    handoff("sh");

    $display("[TB] misaligned LW");
    s = '{default: '0};
    s.regwrite = 1'b1; s.memread = 1'b1; s.ropcode = 3'd2; s.rd = 5'd9;
    s.alu = 32'h8000_0001;
    applyStimulus(s, expFrom(s, 32'h0, 1'b1));
    checkOutput("mis_lw_no_req",    32'(mem_req_valid), 32'd0);
    checkOutput("mis_lw_out_valid", 32'(out_valid),     32'd1);
    handoff("mis_lw");

    $display("[TB] misaligned LHU");
    s.ropcode = 3'd5; s.alu = 32'h8000_0005;
    applyStimulus(s, expFrom(s, 32'h0, 1'b1));
    checkOutput("mis_lhu_no_req", 32'(mem_req_valid), 32'd0);
    handoff("mis_lhu");

    $display("[TB] backpressure after load");
    s = '{default: '0};
    s.regwrite = 1'b1; s.memread = 1'b1; s.ropcode = 3'd2; s.rd = 5'd12;
    s.alu = 32'h8000_0004;
    applyStimulus(s, expFrom(s, 32'h1234_5678, 1'b0));
    doMemOp("bp", 1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, 0, 32'h1234_5678);
    waitOutValid("bp");
    in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd30; in_alu_result = 32'h5555_0000;
    for (int c = 0; c < 4; c++) begin
      checkOutput("bp_out_valid", 32'(out_valid),   32'd1);
      checkOutput("bp_in_ready",  32'(in_ready),    32'd0);
      checkOutput("bp_load_data", out_load_data,    32'h1234_5678);
      checkOutput("bp_rd",        32'(out_rd),      32'd12);
      checkOutput("bp_alu",       out_alu_result,   32'h8000_0004);
      step();
    end
    in_valid = 1'b0;
    handoff("bp");
    step();
    checkOutput("bp_not_accepted", 32'(out_valid), 32'd0);

    $display("[TB] load sweep");
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    foreach (ops[i]) begin
      s = '{default: '0};
      s.regwrite = 1'b1; s.memread = 1'b1; s.ropcode = ops[i];
      s.rd = 5'(i + 1);
      case (ops[i])
        3'd1, 3'd5: off = 2'($urandom_range(0, 1) * 2);
        3'd2:       off = 2'd0;
        default:    off = 2'($urandom_range(0, 3));
      endcase
      s.alu = 32'h8000_1000 + 32'(off);
      rd_word = $urandom();
      rd_word[8*off+7] = i[0];
      applyStimulus(s, expFrom(s, modelLoad(rd_word, off, ops[i]), 1'b0));
      doMemOp("sweep", 1'b0, 32'h8000_1000, 32'h0, 4'h0, i % 2, i % 3, rd_word);
      waitOutValid("sweep");
      handoff("sweep");
    end

    $display("[TB] reset during WAIT");
    s = '{default: '0};
    s.regwrite = 1'b1; s.memread = 1'b1; s.ropcode = 3'd2; s.rd = 5'd3;
    s.alu = 32'h8000_0008;
    applyStimulus(s, expFrom(s, 32'hDEAD_BEEF, 1'b0));
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    exp_q.delete();
    checkOutput("rstw_in_ready",  32'(in_ready),      32'd1);
    checkOutput("rstw_out_valid", 32'(out_valid),     32'd0);
    checkOutput("rstw_req_valid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("stale_out_valid", 32'(out_valid),     32'd0);
      checkOutput("stale_in_ready",  32'(in_ready),      32'd1);
      checkOutput("stale_load_data", out_load_data,      32'h0);
      checkOutput("stale_req_valid", 32'(mem_req_valid), 32'd0);
      step();
    end

    $display("[TB] ALU op after reset");
    s = '{default: '0};
    s.regwrite = 1'b1; s.rd = 5'd31; s.alu = 32'hA5A5_0F0F;
    applyStimulus(s, expFrom(s, 32'h0, 1'b0));
    waitOutValid("post");
    handoff("post");

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
